fetch_redirect_ctrl: RTL and testbench
======================================

// Module: fetch_redirect_ctrl
// PURPOSE
//  Sequencer for the instruction fetch unit: drives its PCWrite, Jump and NewPC
//  inputs, plus IF/ID and ID/EX pipeline-register write/flush controls.
//  Arbitrates between EX-stage branch redirects, ID-stage jumps, load-use stalls
//  and a not-ready instruction memory. Keeps saturating stall/redirect counters.
// PARAMETERS
//  BOOT_CYCLES 2   cycles after reset with fetch held and IF/ID flushed (>=1)
//  CNT_W       16  width of performance counters
// PORTS
//  Clk           in   1      single clock, all state updates on posedge
//  Reset         in   1      synchronous, active-high
//  ImemReady     in   1      instruction memory output valid this cycle
//  BranchTaken   in   1      EX-stage branch resolved taken
//  BranchTarget  in   64     EX-stage branch target
//  JumpReq       in   1      ID-stage unconditional jump
//  JumpTarget    in   64     ID-stage jump target
//  LoadUseHazard in   1      hazard unit load-use detect
//  PCWrite       out  1      to fetch unit: PC loads next value
//  Jump          out  1      to fetch unit: select NewPC over PC+4
//  NewPC         out  64     redirect target
//  IFIDWrite     out  1      IF/ID register load enable
//  IFIDFlush     out  1      IF/ID register clear (bubble)
//  IDEXFlush     out  1      ID/EX register clear (bubble)
//  State         out  2      BOOT=0 RUN=1 STALL=2 REDIR=3
//  StallCnt      out  CNT_W  cycles with PCWrite=0 outside BOOT, saturating
//  RedirCnt      out  CNT_W  accepted redirects (branch+jump), saturating
// BEHAVIOUR
//  - State, pending target (64b), boot counter and perf counters are registered;
//    control outputs are combinational from State and inputs (same-cycle to IF).
//  - Reset cycle and reset values: State=BOOT, boot counter=0, StallCnt=RedirCnt=0,
//    pending=0; outputs PCWrite=0 Jump=0 NewPC=0 IFIDWrite=0 IFIDFlush=1 IDEXFlush=1.
//    Reset wins over every other input in any state, mid-redirect included.
//  - Default (no condition): Jump=0, NewPC=0, IFIDFlush=0, IDEXFlush=0.
//  - BOOT: PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXFlush=1; all requests ignored.
//    After BOOT_CYCLES cycles -> RUN.
//  - RUN, priority BranchTaken > JumpReq > LoadUseHazard > !ImemReady:
//    * BranchTaken & ImemReady: Jump=1 NewPC=BranchTarget PCWrite=1 IFIDWrite=1
//      IFIDFlush=1 IDEXFlush=1; RedirCnt++; stay RUN.
//    * BranchTaken & !ImemReady: pending<=BranchTarget, IFIDFlush=1 IDEXFlush=1,
//      PCWrite=0; RedirCnt++; -> REDIR.
//    * JumpReq: as branch with JumpTarget, but IDEXFlush=0 (jump continues).
//    * LoadUseHazard: PCWrite=0 IFIDWrite=0 IDEXFlush=1; stay RUN (one cycle per
//      asserted cycle). A simultaneous branch/jump discards the hazard.
//    * !ImemReady: PCWrite=0 IFIDWrite=1 IFIDFlush=1; -> STALL.
//    * else: PCWrite=1 IFIDWrite=1.
//  - STALL: PCWrite=0, IFIDFlush=1 until ImemReady; branch in STALL behaves as RUN
//    branch with !ImemReady (-> REDIR); JumpReq ignored (ID holds a bubble).
//    On ImemReady (no branch): PCWrite=1 IFIDWrite=1 -> RUN.
//  - REDIR: Jump=1 NewPC=pending IFIDFlush=1, PCWrite=0 until ImemReady, then
//    PCWrite=1 -> RUN. BranchTaken/JumpReq ignored (wrong-path instructions).
//  - StallCnt increments every non-BOOT cycle with PCWrite=0; both counters
//    saturate at 2^CNT_W-1, never wrap.
//  - NewPC passed unmodified (64b); no alignment check.
// TESTING
//  1 Reset 1 cycle, then idle ImemReady=1 -> State BOOT for 2 cycles, PCWrite=0;
//    cycle 3 State=RUN, PCWrite=1 every cycle, counters 0.
//  2 RUN, BranchTaken=1 BranchTarget=0x40 with JumpReq=1 JumpTarget=0x80 ->
//    Jump=1 NewPC=0x40 IFIDFlush=IDEXFlush=1 same cycle; RedirCnt=1.
//  3 RUN, LoadUseHazard 2 cycles -> PCWrite=0 IFIDWrite=0 IDEXFlush=1 both cycles;
//    StallCnt=2; third cycle PCWrite=1.
//  4 RUN, BranchTaken target 0x100 with ImemReady=0 for 3 cycles -> REDIR, NewPC=0x100
//    held, PCWrite=0 until ImemReady=1, then PCWrite=1 Jump=1 and State=RUN.
//  5 REDIR with Reset=1 -> next cycle State=BOOT, Jump=0, pending=0, counters 0.
//  6 Force StallCnt to 0xFFFF (CNT_W=16), stall again -> StallCnt stays 0xFFFF.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-unit sequencer: arbitrates branch/jump redirects, load-use stalls and imem waits.
// Control outputs are combinational from registered state; perf counters saturate.
module fetch_redirect_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ImemReady,
  input  logic             BranchTaken,
  input  logic [63:0]      BranchTarget,
  input  logic             JumpReq,
  input  logic [63:0]      JumpTarget,
  input  logic             LoadUseHazard,
  output logic             PCWrite,
  output logic             Jump,
  output logic [63:0]      NewPC,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic [1:0]       State,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] RedirCnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2,
    REDIR = 2'd3
  } state_t;

  localparam int BW = $clog2(BOOT_CYCLES + 1);

  state_t           state, state_nxt;
  logic [63:0]      pending, pending_nxt;
  logic [63:0]      tgt;
  logic [BW-1:0]    boot_cnt;
  logic [CNT_W-1:0] stall_cnt, redir_cnt;
  logic             redir_acc;
  logic             boot_done;

  assign boot_done = (boot_cnt == BW'(BOOT_CYCLES - 1));

  always_comb begin
    PCWrite     = 1'b0;
    Jump        = 1'b0;
    NewPC       = '0;
    IFIDWrite   = 1'b0;
    IFIDFlush   = 1'b0;
    IDEXFlush   = 1'b0;
    state_nxt   = state;
    pending_nxt = pending;
    redir_acc   = 1'b0;
    tgt         = BranchTaken ? BranchTarget : JumpTarget;
    if (Reset) begin
      IFIDFlush = 1'b1;
      IDEXFlush = 1'b1;
      state_nxt = BOOT;
    end else begin
      case (state)
        BOOT: begin
          IFIDFlush = 1'b1;
          IDEXFlush = 1'b1;
          if (boot_done) state_nxt = RUN;
        end
        RUN: begin
          if (BranchTaken || JumpReq) begin
            // A jump keeps its ID-stage instruction moving; a branch squashes it.
            redir_acc = 1'b1;
            IFIDFlush = 1'b1;
            IDEXFlush = BranchTaken;
            if (ImemReady) begin
              Jump      = 1'b1;
              NewPC     = tgt;
              PCWrite   = 1'b1;
              IFIDWrite = 1'b1;
            end else begin
              pending_nxt = tgt;
              state_nxt   = REDIR;
            end
          end else if (LoadUseHazard) begin
            IDEXFlush = 1'b1;
          end else if (!ImemReady) begin
            IFIDWrite = 1'b1;
            IFIDFlush = 1'b1;
            state_nxt = STALL;
          end else begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
          end
        end
        STALL: begin
          if (BranchTaken) begin
            redir_acc   = 1'b1;
            IFIDFlush   = 1'b1;
            IDEXFlush   = 1'b1;
            pending_nxt = BranchTarget;
            state_nxt   = REDIR;
          end else if (ImemReady) begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
            state_nxt = RUN;
          end else begin
            IFIDWrite = 1'b1;
            IFIDFlush = 1'b1;
          end
        end
        REDIR: begin
          // Target is presented every cycle until imem can accept the PC load.
          Jump      = 1'b1;
          NewPC     = pending;
          IFIDFlush = 1'b1;
          if (ImemReady) begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
            state_nxt = RUN;
          end
        end
        default: state_nxt = BOOT;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= BOOT;
      pending   <= '0;
      boot_cnt  <= '0;
      stall_cnt <= '0;
      redir_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pending  <= pending_nxt;
      boot_cnt <= (state == BOOT) ? boot_cnt + 1'b1 : '0;
      if (state != BOOT && !PCWrite && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (redir_acc && redir_cnt != '1)
        redir_cnt <= redir_cnt + 1'b1;
    end
  end

  assign State    = state;
  assign StallCnt = stall_cnt;
  assign RedirCnt = redir_cnt;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed-vector bench for fetch_redirect_ctrl.
module tb_fetch_redirect_ctrl;

  logic        Clk = 1'b0;
  logic        Reset, ImemReady, BranchTaken, JumpReq, LoadUseHazard;
  logic [63:0] BranchTarget, JumpTarget;
  logic        PCWrite, Jump, IFIDWrite, IFIDFlush, IDEXFlush;
  logic [63:0] NewPC;
  logic [1:0]  State;
  logic [15:0] StallCnt, RedirCnt;

  int tests = 0;
  int fails = 0;

  fetch_redirect_ctrl #(.BOOT_CYCLES(2), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .ImemReady(ImemReady),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .JumpReq(JumpReq), .JumpTarget(JumpTarget), .LoadUseHazard(LoadUseHazard),
    .PCWrite(PCWrite), .Jump(Jump), .NewPC(NewPC), .IFIDWrite(IFIDWrite),
    .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush), .State(State),
    .StallCnt(StallCnt), .RedirCnt(RedirCnt)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step(); #1;
    tests++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL rst_pcwrite got %b exp 0", PCWrite); end
    tests++; if (Jump !== 1'b0) begin fails++; $display("FAIL rst_jump got %b exp 0", Jump); end
    tests++; if (NewPC !== 64'h0) begin fails++; $display("FAIL rst_newpc got %h exp 0", NewPC); end
    tests++; if (IFIDWrite !== 1'b0) begin fails++; $display("FAIL rst_ifidwrite got %b exp 0", IFIDWrite); end
    tests++; if (IFIDFlush !== 1'b1) begin fails++; $display("FAIL rst_ifidflush got %b exp 1", IFIDFlush); end
    tests++; if (IDEXFlush !== 1'b1) begin fails++; $display("FAIL rst_idexflush got %b exp 1", IDEXFlush); end
    step(); Reset = 1'b0; #1;
    tests++; if (State !== 2'd0) begin fails++; $display("FAIL boot1_state got %0d exp 0", State); end
    tests++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL boot1_pcwrite got %b exp 0", PCWrite); end
    tests++; if (IFIDFlush !== 1'b1) begin fails++; $display("FAIL boot1_ifidflush got %b exp 1", IFIDFlush); end
    step(); #1;
    tests++; if (State !== 2'd0) begin fails++; $display("FAIL boot2_state got %0d exp 0", State); end
    tests++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL boot2_pcwrite got %b exp 0", PCWrite); end
    step(); #1;
    tests++; if (State !== 2'd1) begin fails++; $display("FAIL run_state got %0d exp 1", State); end
    tests++; if (PCWrite !== 1'b1) begin fails++; $display("FAIL run_pcwrite got %b exp 1", PCWrite); end
    tests++; if (IFIDWrite !== 1'b1) begin fails++; $display("FAIL run_ifidwrite got %b exp 1", IFIDWrite); end
    tests++; if (StallCnt !== 16'd0) begin fails++; $display("FAIL run_stallcnt got %0d exp 0", StallCnt); end
    tests++; if (RedirCnt !== 16'd0) begin fails++; $display("FAIL run_redircnt got %0d exp 0", RedirCnt); end
    step(); #1;
    tests++; if (PCWrite !== 1'b1) begin fails++; $display("FAIL run2_pcwrite got %b exp 1", PCWrite); end
  endtask

  task automatic test_branch_priority();
    step();
    BranchTaken = 1'b1; BranchTarget = 64'h40; JumpReq = 1'b1; JumpTarget = 64'h80;
    #1;
    tests++; if (Jump !== 1'b1) begin fails++; $display("FAIL br_jump got %b exp 1", Jump); end
    tests++; if (NewPC !== 64'h40) begin fails++; $display("FAIL br_newpc got %h exp 40", NewPC); end
    tests++; if (IFIDFlush !== 1'b1) begin fails++; $display("FAIL br_ifidflush got %b exp 1", IFIDFlush); end
    tests++; if (IDEXFlush !== 1'b1) begin fails++; $display("FAIL br_idexflush got %b exp 1", IDEXFlush); end
    tests++; if (PCWrite !== 1'b1) begin fails++; $display("FAIL br_pcwrite got %b exp 1", PCWrite); end
    step(); BranchTaken = 1'b0; JumpReq = 1'b0; #1;
    tests++; if (RedirCnt !== 16'd1) begin fails++; $display("FAIL br_redircnt got %0d exp 1", RedirCnt); end
    tests++; if (State !== 2'd1) begin fails++; $display("FAIL br_state got %0d exp 1", State); end
  endtask

  task automatic test_jump();
    step();
    JumpReq = 1'b1; JumpTarget = 64'h80; LoadUseHazard = 1'b1;
    #1;
    tests++; if (Jump !== 1'b1) begin fails++; $display("FAIL jmp_jump got %b exp 1", Jump); end
    tests++; if (NewPC !== 64'h80) begin fails++; $display("FAIL jmp_newpc got %h exp 80", NewPC); end
    tests++; if (IDEXFlush !== 1'b0) begin fails++; $display("FAIL jmp_idexflush got %b exp 0", IDEXFlush); end
    tests++; if (IFIDFlush !== 1'b1) begin fails++; $display("FAIL jmp_ifidflush got %b exp 1", IFIDFlush); end
    tests++; if (PCWrite !== 1'b1) begin fails++; $display("FAIL jmp_pcwrite got %b exp 1", PCWrite); end
    step(); JumpReq = 1'b0; LoadUseHazard = 1'b0; #1;
    tests++; if (RedirCnt !== 16'd2) begin fails++; $display("FAIL jmp_redircnt got %0d exp 2", RedirCnt); end
    tests++; if (StallCnt !== 16'd0) begin fails++; $display("FAIL jmp_stallcnt got %0d exp 0", StallCnt); end
  endtask

  task automatic test_load_use();
    step(); LoadUseHazard = 1'b1; #1;
    tests++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL lu1_pcwrite got %b exp 0", PCWrite); end
    tests++; if (IFIDWrite !== 1'b0) begin fails++; $display("FAIL lu1_ifidwrite got %b exp 0", IFIDWrite); end
    tests++; if (IDEXFlush !== 1'b1) begin fails++; $display("FAIL lu1_idexflush got %b exp 1", IDEXFlush); end
    step(); #1;
    tests++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL lu2_pcwrite got %b exp 0", PCWrite); end
    tests++; if (IFIDWrite !== 1'b0) begin fails++; $display("FAIL lu2_ifidwrite got %b exp 0", IFIDWrite); end
    tests++; if (IDEXFlush !== 1'b1) begin fails++; $display("FAIL lu2_idexflush got %b exp 1", IDEXFlush); end
    step(); LoadUseHazard = 1'b0; #1;
    tests++; if (StallCnt !== 16'd2) begin fails++; $display("FAIL lu_stallcnt got %0d exp 2", StallCnt); end
    tests++; if (PCWrite !== 1'b1) begin fails++; $display("FAIL lu3_pcwrite got %b exp 1", PCWrite); end
  endtask

  task automatic test_redirect();
    step(); BranchTaken = 1'b1; BranchTarget = 64'h100; ImemReady = 1'b0; #1;
    tests++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL rd0_pcwrite got %b exp 0", PCWrite); end
    tests++; if (IFIDFlush !== 1'b1) begin fails++; $display("FAIL rd0_ifidflush got %b exp 1", IFIDFlush); end
    tests++; if (IDEXFlush !== 1'b1) begin fails++; $display("FAIL rd0_idexflush got %b exp 1", IDEXFlush); end
    tests++; if (Jump !== 1'b0) begin fails++; $display("FAIL rd0_jump got %b exp 0", Jump); end
    step(); BranchTaken = 1'b0; #1;
    tests++; if (State !== 2'd3) begin fails++; $display("FAIL rd1_state got %0d exp 3", State); end
    tests++; if (Jump !== 1'b1) begin fails++; $display("FAIL rd1_jump got %b exp 1", Jump); end
    tests++; if (NewPC !== 64'h100) begin fails++; $display("FAIL rd1_newpc got %h exp 100", NewPC); end
    tests++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL rd1_pcwrite got %b exp 0", PCWrite); end
    step(); BranchTaken = 1'b1; BranchTarget = 64'h999; #1;
    tests++; if (NewPC !== 64'h100) begin fails++; $display("FAIL rd2_newpc got %h exp 100", NewPC); end
    tests++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL rd2_pcwrite got %b exp 0", PCWrite); end
    step(); BranchTaken = 1'b0; ImemReady = 1'b1; #1;
    tests++; if (PCWrite !== 1'b1) begin fails++; $display("FAIL rd3_pcwrite got %b exp 1", PCWrite); end
    tests++; if (Jump !== 1'b1) begin fails++; $display("FAIL rd3_jump got %b exp 1", Jump); end
    tests++; if (NewPC !== 64'h100) begin fails++; $display("FAIL rd3_newpc got %h exp 100", NewPC); end
    step(); #1;
    tests++; if (State !== 2'd1) begin fails++; $display("FAIL rd_state got %0d exp 1", State); end
    tests++; if (RedirCnt !== 16'd3) begin fails++; $display("FAIL rd_redircnt got %0d exp 3", RedirCnt); end
    tests++; if (StallCnt !== 16'd5) begin fails++; $display("FAIL rd_stallcnt got %0d exp 5", StallCnt); end
  endtask

  task automatic test_imem_stall();
    step(); ImemReady = 1'b0; #1;
    tests++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL st0_pcwrite got %b exp 0", PCWrite); end
    tests++; if (IFIDFlush !== 1'b1) begin fails++; $display("FAIL st0_ifidflush got %b exp 1", IFIDFlush); end
    step(); JumpReq = 1'b1; JumpTarget = 64'h200; #1;
    tests++; if (State !== 2'd2) begin fails++; $display("FAIL st1_state got %0d exp 2", State); end
    tests++; if (Jump !== 1'b0) begin fails++; $display("FAIL st1_jump got %b exp 0", Jump); end
    tests++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL st1_pcwrite got %b exp 0", PCWrite); end
    step(); JumpReq = 1'b0; ImemReady = 1'b1; #1;
    tests++; if (PCWrite !== 1'b1) begin fails++; $display("FAIL st2_pcwrite got %b exp 1", PCWrite); end
    tests++; if (IFIDWrite !== 1'b1) begin fails++; $display("FAIL st2_ifidwrite got %b exp 1", IFIDWrite); end
    step(); #1;
    tests++; if (State !== 2'd1) begin fails++; $display("FAIL st_state got %0d exp 1", State); end
    tests++; if (StallCnt !== 16'd7) begin fails++; $display("FAIL st_stallcnt got %0d exp 7", StallCnt); end
    tests++; if (RedirCnt !== 16'd3) begin fails++; $display("FAIL st_redircnt got %0d exp 3", RedirCnt); end
  endtask

  task automatic test_reset_in_redir();
    step(); BranchTaken = 1'b1; BranchTarget = 64'h300; ImemReady = 1'b0;
    step(); BranchTaken = 1'b0; #1;
    tests++; if (State !== 2'd3) begin fails++; $display("FAIL rr_pre_state got %0d exp 3", State); end
    Reset = 1'b1; #1;
    tests++; if (Jump !== 1'b0) begin fails++; $display("FAIL rr_jump got %b exp 0", Jump); end
    tests++; if (NewPC !== 64'h0) begin fails++; $display("FAIL rr_newpc got %h exp 0", NewPC); end
    tests++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL rr_pcwrite got %b exp 0", PCWrite); end
    step(); Reset = 1'b0; ImemReady = 1'b1; #1;
    tests++; if (State !== 2'd0) begin fails++; $display("FAIL rr_state got %0d exp 0", State); end
    tests++; if (Jump !== 1'b0) begin fails++; $display("FAIL rr_boot_jump got %b exp 0", Jump); end
    tests++; if (dut.pending !== 64'h0) begin fails++; $display("FAIL rr_pending got %h exp 0", dut.pending); end
    tests++; if (StallCnt !== 16'd0) begin fails++; $display("FAIL rr_stallcnt got %0d exp 0", StallCnt); end
    tests++; if (RedirCnt !== 16'd0) begin fails++; $display("FAIL rr_redircnt got %0d exp 0", RedirCnt); end
    step(); step(); #1;
    tests++; if (State !== 2'd1) begin fails++; $display("FAIL rr_run_state got %0d exp 1", State); end
  endtask

  task automatic test_saturation();
    step(); force dut.stall_cnt = 16'hFFFF; LoadUseHazard = 1'b1; #1;
    tests++; if (PCWrite !== 1'b0) begin fails++; $display("FAIL sat_pcwrite got %b exp 0", PCWrite); end
    step(); release dut.stall_cnt; #1;
    tests++; if (StallCnt !== 16'hFFFF) begin fails++; $display("FAIL sat1_stallcnt got %h exp ffff", StallCnt); end
    step(); #1;
    tests++; if (StallCnt !== 16'hFFFF) begin fails++; $display("FAIL sat2_stallcnt got %h exp ffff", StallCnt); end
    LoadUseHazard = 1'b0;
    step(); #1;
    tests++; if (StallCnt !== 16'hFFFF) begin fails++; $display("FAIL sat3_stallcnt got %h exp ffff", StallCnt); end
  endtask

  initial begin
    Reset = 1'b1; ImemReady = 1'b1; BranchTaken = 1'b0; JumpReq = 1'b0;
    LoadUseHazard = 1'b0; BranchTarget = '0; JumpTarget = '0;
    test_reset();
    test_branch_priority();
    test_jump();
    test_load_use();
    test_redirect();
    test_imem_stall();
    test_reset_in_redir();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "timeout");
  end

endmodule
